// File: rtl/sound_arbiter_if.sv
// Request/status bundle between the sound requesters and the arbiter.
// master drives the requests, slave (the arbiter) drives the player controls.
interface sound_arbiter_if;
  logic       alarm_req;
  logic       beep_req;
  logic       tune_req;
  logic [1:0] tune_sel;
  logic [2:0] mode;
  logic       beep_trigger;
  logic [2:0] grant;
  logic       busy;
  logic       done;

  modport master (
    output alarm_req, beep_req, tune_req, tune_sel,
    input  mode, beep_trigger, grant, busy, done
  );

  modport slave (
    input  alarm_req, beep_req, tune_req, tune_sel,
    output mode, beep_trigger, grant, busy, done
  );
endinterface

// File: rtl/sound_arbiter.sv
// Priority arbiter (alarm > beep > tune) driving the music player mode.
// Optional macro SOUND_ARB_BEEP_QUEUE_EN adds a one-deep pending-beep flag.
module sound_arbiter #(
  parameter int unsigned BEEP_CYCLES = 10000000,
  parameter int unsigned TUNE_CYCLES = 200000000
) (
  input  logic            clk_100mHz,
  input  logic            rst_n,
  sound_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TUNE  = 2'd1,
    S_BEEP  = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  localparam logic [31:0] BEEP_LAST = 32'(BEEP_CYCLES - 1);
  localparam logic [31:0] TUNE_LAST = 32'(TUNE_CYCLES - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_count;
  logic [1:0]  r_tune_sel;
  logic [1:0]  w_tune_sel;
  logic        w_pending;
  logic        w_done;
  logic [2:0]  w_mode;
  logic        w_beep_trigger;
  logic [2:0]  w_grant;
  logic        w_busy;
  logic [2:0]  r_mode;
  logic        r_beep_trigger;
  logic [2:0]  r_grant;
  logic        r_busy;
  logic        r_done;

  // State register, duration counter and latched tune selection
  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= 32'd0;
      r_tune_sel <= 2'b00;
    end else begin
      r_state    <= w_next_state;
      r_tune_sel <= w_tune_sel;
      if (w_next_state != r_state) begin
        r_count <= 32'd0;
      end else if (r_count != 32'hFFFF_FFFF) begin
        r_count <= r_count + 32'd1;
      end else begin
        r_count <= r_count;
      end
    end
  end

`ifdef SOUND_ARB_BEEP_QUEUE_EN
  logic r_pending;

  // Pending beep: set by a beep arriving while busy, cleared on beep entry
  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (r_state == S_IDLE && w_next_state == S_BEEP) begin
      r_pending <= 1'b0;
    end else if (bus.beep_req && r_state != S_IDLE) begin
      r_pending <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  assign w_pending = r_pending;
`else
  assign w_pending = 1'b0;
`endif

  // Next-state and completion decode; alarm always wins, even on a completion edge
  always_comb begin
    w_next_state = r_state;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.alarm_req) begin
          w_next_state = S_ALARM;
        end else if (bus.beep_req || w_pending) begin
          w_next_state = S_BEEP;
        end else if (bus.tune_req && bus.tune_sel != 2'b00) begin
          w_next_state = S_TUNE;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_TUNE: begin
        if (bus.alarm_req) begin
          w_next_state = S_ALARM;
        end else if (r_count == TUNE_LAST) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end else begin
          w_next_state = S_TUNE;
        end
      end
      S_BEEP: begin
        if (bus.alarm_req) begin
          w_next_state = S_ALARM;
        end else if (r_count == BEEP_LAST) begin
          w_next_state = S_IDLE;
          w_done       = 1'b1;
        end else begin
          w_next_state = S_BEEP;
        end
      end
      S_ALARM: begin
        if (bus.alarm_req) begin
          w_next_state = S_ALARM;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so outputs change on the same edge
  always_comb begin
    w_tune_sel     = r_tune_sel;
    w_mode         = 3'b000;
    w_beep_trigger = 1'b0;
    w_grant        = 3'b000;
    w_busy         = 1'b1;
    if (r_state == S_IDLE && w_next_state == S_TUNE) begin
      w_tune_sel = bus.tune_sel;
    end else begin
      w_tune_sel = r_tune_sel;
    end
    case (w_next_state)
      S_IDLE: begin
        w_busy = 1'b0;
      end
      S_TUNE: begin
        w_mode  = {1'b0, w_tune_sel};
        w_grant = 3'b001;
      end
      S_BEEP: begin
        w_mode         = 3'b100;
        w_beep_trigger = 1'b1;
        w_grant        = 3'b010;
      end
      S_ALARM: begin
        w_mode  = 3'b011;
        w_grant = 3'b100;
      end
      default: begin
        w_busy = 1'b0;
      end
    endcase
  end

  // Output registers; async reset silences the player without a clock edge
  always_ff @(posedge clk_100mHz or negedge rst_n) begin
    if (!rst_n) begin
      r_mode         <= 3'b000;
      r_beep_trigger <= 1'b0;
      r_grant        <= 3'b000;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_mode         <= w_mode;
      r_beep_trigger <= w_beep_trigger;
      r_grant        <= w_grant;
      r_busy         <= w_busy;
      r_done         <= w_done;
    end
  end

  assign bus.mode         = r_mode;
  assign bus.beep_trigger = r_beep_trigger;
  assign bus.grant        = r_grant;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;

endmodule

// File: tb/tb_sound_arbiter.sv
// Scoreboard bench for sound_arbiter: a driver pushes the reference model's
// expected outputs per cycle, a monitor pops and compares after each edge.
module tb_sound_arbiter;
  localparam int BEEP_N = 4;
  localparam int TUNE_N = 8;
  localparam int A_NONE  = 0;
  localparam int A_TUNE  = 1;
  localparam int A_BEEP  = 2;
  localparam int A_ALARM = 3;

  typedef struct packed {
    logic [2:0] mode;
    logic       trig;
    logic [2:0] grant;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  sound_arbiter_if bus();

  sound_arbiter #(.BEEP_CYCLES(BEEP_N), .TUNE_CYCLES(TUNE_N)) dut (
    .clk_100mHz (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  int         m_act = A_NONE;
  int         m_el = 0;
  logic [1:0] m_sel = 2'b00;
  bit         m_pend = 1'b0;
  bit         m_done = 1'b0;

  function automatic exp_t dut_out();
    return {bus.mode, bus.beep_trigger, bus.grant, bus.busy, bus.done};
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got mode=%b trig=%b grant=%b busy=%b done=%b, expected mode=%b trig=%b grant=%b busy=%b done=%b",
               name, $time, act.mode, act.trig, act.grant, act.busy, act.done,
               exp.mode, exp.trig, exp.grant, exp.busy, exp.done);
    end
  endtask

  // Outputs that the player should see for the model's current activity
  function automatic exp_t model_out();
    exp_t e;
    e = '0;
    e.done = m_done;
    case (m_act)
      A_TUNE:  begin e.mode = {1'b0, m_sel}; e.grant = 3'b001; e.busy = 1'b1; end
      A_BEEP:  begin e.mode = 3'b100; e.trig = 1'b1; e.grant = 3'b010; e.busy = 1'b1; end
      A_ALARM: begin e.mode = 3'b011; e.grant = 3'b100; e.busy = 1'b1; end
      default: e = e;
    endcase
    return e;
  endfunction

  // Reference behaviour: activity plus number of cycles already played
  task automatic model_step(input bit a, input bit b, input bit t, input logic [1:0] s);
    bit queue_en;
`ifdef SOUND_ARB_BEEP_QUEUE_EN
    queue_en = 1'b1;
`else
    queue_en = 1'b0;
`endif
    m_done = 1'b0;
    if (m_act == A_NONE) begin
      if (a) m_act = A_ALARM;
      else if (b || m_pend) begin m_act = A_BEEP; m_el = 1; m_pend = 1'b0; end
      else if (t && s != 2'b00) begin m_act = A_TUNE; m_el = 1; m_sel = s; end
    end else begin
      if (b && queue_en) m_pend = 1'b1;
      if (m_act == A_ALARM) begin
        if (!a) m_act = A_NONE;
      end else if (a) begin
        m_act = A_ALARM;
      end else if (m_el == ((m_act == A_TUNE) ? TUNE_N : BEEP_N)) begin
        m_act = A_NONE;
        m_done = 1'b1;
      end else begin
        m_el++;
      end
    end
  endtask

  task automatic step(input bit a, input bit b, input bit t, input logic [1:0] s);
    @(negedge clk);
    bus.alarm_req = a;
    bus.beep_req  = b;
    bus.tune_req  = t;
    bus.tune_sel  = s;
    model_step(a, b, t, s);
    q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    bus.alarm_req = 1'b0;
    bus.beep_req  = 1'b0;
    bus.tune_req  = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", dut_out(), exp_t'(0));
    @(negedge clk);
    check("reset_hold", dut_out(), exp_t'(0));
    rst_n = 1'b1;
    m_act = A_NONE; m_el = 0; m_pend = 1'b0; m_done = 1'b0; m_sel = 2'b00;
  endtask

  // Monitor: one expected record per clock edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cycle", dut_out(), e);
      end
    end
  end

  initial begin
    bit a_lvl;
    bus.alarm_req = 1'b0;
    bus.beep_req  = 1'b0;
    bus.tune_req  = 1'b0;
    bus.tune_sel  = 2'b00;
    #1 check("reset_state", dut_out(), exp_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    step(1'b0, 1'b0, 1'b1, 2'b10); idle(TUNE_N + 2);
    step(1'b0, 1'b1, 1'b0, 2'b00); idle(BEEP_N + 2);
    step(1'b0, 1'b0, 1'b1, 2'b01); idle(2);
    repeat (3) step(1'b1, 1'b0, 1'b0, 2'b00);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 2'b11); idle(2);
    step(1'b0, 1'b1, 1'b0, 2'b00); idle(TUNE_N + BEEP_N + 4);
    step(1'b1, 1'b1, 1'b1, 2'b01); step(1'b1, 1'b0, 1'b0, 2'b00); idle(3);
    step(1'b0, 1'b0, 1'b1, 2'b00); idle(2);
    step(1'b0, 1'b0, 1'b1, 2'b01); idle(TUNE_N - 1);
    step(1'b0, 1'b1, 1'b0, 2'b00); idle(BEEP_N + 3);
    step(1'b0, 1'b1, 1'b0, 2'b00); idle(1);
    reset_pulse();
    idle(3);
    a_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!a_lvl && $urandom_range(99) < 2) a_lvl = 1'b1;
      else if (a_lvl && $urandom_range(99) < 25) a_lvl = 1'b0;
      step(a_lvl, $urandom_range(99) < 6, $urandom_range(99) < 10, 2'($urandom_range(3)));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL queue_drain: got %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
